// File: rtl/id_imm_sequencer.sv
// id_imm_sequencer: decode-stage slot controller.
// Holds one fetched instruction between fetch and the ID/EX boundary.
// It decodes the opcode into an immediate-select code for the extend unit
// and inserts a single bubble when the instruction reads a register that
// the load entering EX at the same edge writes.
module id_imm_sequencer #(
  parameter logic [6:0] LOAD_OPCODE = 7'b0000011,
  parameter int         XLEN        = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IF_VALID,
  input  logic [XLEN-1:0] IF_INSTR,
  output logic            IF_READY,
  input  logic            EX_READY,
  input  logic            FLUSH,
  output logic            ID_VALID,
  output logic [XLEN-1:0] ID_INSTR,
  output logic [2:0]      IMM_SEL,
  output logic            HAS_IMM,
  output logic [4:0]      RS1,
  output logic [4:0]      RS2,
  output logic [4:0]      RD,
  output logic            ILLEGAL
);

  // Slot states.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HAZ   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Immediate-select codes understood by the extend unit.
  localparam logic [2:0] SEL_I = 3'd0;
  localparam logic [2:0] SEL_S = 3'd1;
  localparam logic [2:0] SEL_U = 3'd2;
  localparam logic [2:0] SEL_B = 3'd3;
  localparam logic [2:0] SEL_J = 3'd4;

  // Opcode decode table.
  // Result packing: {illegal, uses_rs2, uses_rs1, has_imm, imm_sel[2:0]}.
  // Unknown opcodes are treated as reading rs1 so that a stale value is
  // never consumed without a stall; they otherwise flow as normal.
  function automatic logic [6:0] decode_op(input logic [6:0] op);
    logic [6:0] d;
    case (op)
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011: d = {1'b0, 1'b0, 1'b1, 1'b1, SEL_I};
      7'b0100011: d = {1'b0, 1'b1, 1'b1, 1'b1, SEL_S};
      7'b0110111,
      7'b0010111: d = {1'b0, 1'b0, 1'b0, 1'b1, SEL_U};
      7'b1100011: d = {1'b0, 1'b1, 1'b1, 1'b1, SEL_B};
      7'b1101111: d = {1'b0, 1'b0, 1'b0, 1'b1, SEL_J};
      7'b0110011: d = {1'b0, 1'b1, 1'b1, 1'b0, SEL_I};
      default:    d = {1'b1, 1'b0, 1'b1, 1'b0, SEL_I};
    endcase
    return d;
  endfunction

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_instr;
  logic [2:0]      r_imm_sel;
  logic            r_has_imm;
  logic            r_illegal;

  logic [6:0]      w_dec;
  logic            w_accept;
  logic            w_issue;
  logic            w_hazard;
  logic [4:0]      w_last_ld_rd;

  // Handshake qualifiers. IF_READY is forced low while reset is held.
  assign IF_READY = RESET && !FLUSH &&
                    ((r_state == ST_EMPTY) || ((r_state == ST_FULL) && EX_READY));
  assign ID_VALID = (r_state == ST_FULL);
  assign w_accept = IF_VALID && IF_READY;
  assign w_issue  = ID_VALID && EX_READY;

  // Destination of the load (if any) entering EX at this edge. A cycle
  // without issue sends a bubble into EX, and a load to x0 never creates
  // a dependency, so both yield zero. The hazard check only ever needs
  // this post-edge value, which also covers issue and accept together.
  assign w_last_ld_rd = (w_issue && (r_instr[6:0] == LOAD_OPCODE)) ? r_instr[11:7] : 5'd0;

  assign w_dec = decode_op(IF_INSTR[6:0]);

  assign w_hazard = (w_last_ld_rd != 5'd0) &&
                    ((w_dec[4] && (IF_INSTR[19:15] == w_last_ld_rd)) ||
                     (w_dec[5] && (IF_INSTR[24:20] == w_last_ld_rd)));

  // Next-state selection; flush overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    if (FLUSH) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = w_hazard ? ST_HAZ : ST_FULL;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_HAZ: begin
          w_state_nxt = ST_FULL;
        end
        ST_FULL: begin
          if (w_accept) begin
            w_state_nxt = w_hazard ? ST_HAZ : ST_FULL;
          end else if (w_issue) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Slot state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot contents and decode results, captured only on accept so they
  // stay stable through stalls and remain readable while the slot is empty.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_instr   <= {XLEN{1'b0}};
      r_imm_sel <= 3'd0;
      r_has_imm <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_instr   <= IF_INSTR;
      r_imm_sel <= w_dec[2:0];
      r_has_imm <= w_dec[3];
      r_illegal <= w_dec[6];
    end
  end

  assign ID_INSTR = r_instr;
  assign IMM_SEL  = r_imm_sel;
  assign HAS_IMM  = r_has_imm;
  assign ILLEGAL  = r_illegal;
  assign RS1      = r_instr[19:15];
  assign RS2      = r_instr[24:20];
  assign RD       = r_instr[11:7];

endmodule

// File: tb/tb_id_imm_sequencer.sv
// tb_id_imm_sequencer: table-driven check of the decode-stage sequencer,
// followed by hand-written reset sequences.
module tb_id_imm_sequencer;

  logic        CLK;
  logic        RESET;
  logic        IF_VALID;
  logic [31:0] IF_INSTR;
  logic        IF_READY;
  logic        EX_READY;
  logic        FLUSH;
  logic        ID_VALID;
  logic [31:0] ID_INSTR;
  logic [2:0]  IMM_SEL;
  logic        HAS_IMM;
  logic [4:0]  RS1;
  logic [4:0]  RS2;
  logic [4:0]  RD;
  logic        ILLEGAL;

  int total_checks;
  int passed_checks;

  id_imm_sequencer dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IF_VALID (IF_VALID),
    .IF_INSTR (IF_INSTR),
    .IF_READY (IF_READY),
    .EX_READY (EX_READY),
    .FLUSH    (FLUSH),
    .ID_VALID (ID_VALID),
    .ID_INSTR (ID_INSTR),
    .IMM_SEL  (IMM_SEL),
    .HAS_IMM  (HAS_IMM),
    .RS1      (RS1),
    .RS2      (RS2),
    .RD       (RD),
    .ILLEGAL  (ILLEGAL)
  );

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [31:0] ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] SW   = 32'h00112223; // sw   x1,4(x2)
  localparam logic [31:0] LUI  = 32'h123451B7; // lui  x3,0x12345
  localparam logic [31:0] BEQ  = 32'h00208463; // beq  x1,x2,+8
  localparam logic [31:0] JAL  = 32'h000000EF; // jal  x1,0
  localparam logic [31:0] LW5  = 32'h00012283; // lw   x5,0(x2)
  localparam logic [31:0] ADD6 = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] ILL  = 32'h0000007F; // unknown opcode
  localparam logic [31:0] LUI6 = 32'h00028337; // lui  x6,0x28 (rs1 field = 5)
  localparam logic [31:0] LW0  = 32'h00012003; // lw   x0,0(x2)
  localparam logic [31:0] ADD9 = 32'h000004B3; // add  x9,x0,x0
  localparam logic [31:0] ADD8 = 32'h00538433; // add  x8,x7,x5

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic        er;
    logic        fl;
    logic        rdy;
    logic        vld;
    logic [31:0] e_instr;
    logic [2:0]  e_sel;
    logic        e_has;
    logic        e_ill;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [4:0]  e_rd;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic v, input logic [31:0] instr, input logic er,
                              input logic fl, input logic rdy, input logic vld,
                              input logic [31:0] e_instr, input logic [2:0] e_sel,
                              input logic e_has, input logic e_ill, input logic [4:0] e_rs1,
                              input logic [4:0] e_rs2, input logic [4:0] e_rd);
    vec_t r;
    r.v = v; r.instr = instr; r.er = er; r.fl = fl; r.rdy = rdy; r.vld = vld;
    r.e_instr = e_instr; r.e_sel = e_sel; r.e_has = e_has; r.e_ill = e_ill;
    r.e_rs1 = e_rs1; r.e_rs2 = e_rs2; r.e_rd = e_rd;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      passed_checks++;
    end
  endtask

  task automatic check_fields(input string tag, input logic [31:0] e_instr, input logic [2:0] e_sel,
                              input logic e_has, input logic e_ill, input logic [4:0] e_rs1,
                              input logic [4:0] e_rs2, input logic [4:0] e_rd);
    check({tag, " ID_INSTR"}, ID_INSTR, e_instr);
    check({tag, " IMM_SEL"},  {29'd0, IMM_SEL}, {29'd0, e_sel});
    check({tag, " HAS_IMM"},  {31'd0, HAS_IMM}, {31'd0, e_has});
    check({tag, " ILLEGAL"},  {31'd0, ILLEGAL}, {31'd0, e_ill});
    check({tag, " RS1"},      {27'd0, RS1}, {27'd0, e_rs1});
    check({tag, " RS2"},      {27'd0, RS2}, {27'd0, e_rs2});
    check({tag, " RD"},       {27'd0, RD},  {27'd0, e_rd});
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;

    // Each row: inputs driven for one cycle and the outputs expected during
    // that cycle (ID_* reflect what was accepted at the previous edge).
    //           v     instr er    fl    rdy   vld   ID_INSTR sel  has   ill   rs1   rs2   rd
    tbl[0]  = mk(1'b1, ADDI, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tbl[1]  = mk(1'b1, SW,   1'b1, 1'b0, 1'b1, 1'b1, ADDI,  3'd0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd1);
    tbl[2]  = mk(1'b1, LUI,  1'b1, 1'b0, 1'b1, 1'b1, SW,    3'd1, 1'b1, 1'b0, 5'd2, 5'd1, 5'd4);
    tbl[3]  = mk(1'b1, BEQ,  1'b1, 1'b0, 1'b1, 1'b1, LUI,   3'd2, 1'b1, 1'b0, 5'd8, 5'd3, 5'd3);
    tbl[4]  = mk(1'b1, JAL,  1'b1, 1'b0, 1'b1, 1'b1, BEQ,   3'd3, 1'b1, 1'b0, 5'd1, 5'd2, 5'd8);
    tbl[5]  = mk(1'b1, LW5,  1'b1, 1'b0, 1'b1, 1'b1, JAL,   3'd4, 1'b1, 1'b0, 5'd0, 5'd0, 5'd1);
    tbl[6]  = mk(1'b1, ADD6, 1'b1, 1'b0, 1'b1, 1'b1, LW5,   3'd0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd5);
    // load-use on rs1: one bubble cycle
    tbl[7]  = mk(1'b1, ILL,  1'b1, 1'b0, 1'b0, 1'b0, ADD6,  3'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd6);
    tbl[8]  = mk(1'b1, ILL,  1'b1, 1'b0, 1'b1, 1'b1, ADD6,  3'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd6);
    tbl[9]  = mk(1'b1, LW5,  1'b1, 1'b0, 1'b1, 1'b1, ILL,   3'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    // lui after lw x5 with rs1 field = 5: not read, no bubble
    tbl[10] = mk(1'b1, LUI6, 1'b1, 1'b0, 1'b1, 1'b1, LW5,   3'd0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd5);
    tbl[11] = mk(1'b1, LW0,  1'b1, 1'b0, 1'b1, 1'b1, LUI6,  3'd2, 1'b1, 1'b0, 5'd5, 5'd0, 5'd6);
    // add reading x0 right behind lw x0: no bubble
    tbl[12] = mk(1'b1, ADD9, 1'b1, 1'b0, 1'b1, 1'b1, LW0,   3'd0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0);
    tbl[13] = mk(1'b1, LW5,  1'b1, 1'b0, 1'b1, 1'b1, ADD9,  3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
    // load-use on rs2
    tbl[14] = mk(1'b1, ADD8, 1'b1, 1'b0, 1'b1, 1'b1, LW5,   3'd0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd5);
    tbl[15] = mk(1'b0, ADDI, 1'b1, 1'b0, 1'b0, 1'b0, ADD8,  3'd0, 1'b0, 1'b0, 5'd7, 5'd5, 5'd8);
    // execute stalls three cycles
    tbl[16] = mk(1'b1, ADDI, 1'b0, 1'b0, 1'b0, 1'b1, ADD8,  3'd0, 1'b0, 1'b0, 5'd7, 5'd5, 5'd8);
    tbl[17] = mk(1'b1, ADDI, 1'b0, 1'b0, 1'b0, 1'b1, ADD8,  3'd0, 1'b0, 1'b0, 5'd7, 5'd5, 5'd8);
    tbl[18] = mk(1'b1, ADDI, 1'b0, 1'b0, 1'b0, 1'b1, ADD8,  3'd0, 1'b0, 1'b0, 5'd7, 5'd5, 5'd8);
    tbl[19] = mk(1'b1, ADDI, 1'b1, 1'b0, 1'b1, 1'b1, ADD8,  3'd0, 1'b0, 1'b0, 5'd7, 5'd5, 5'd8);
    tbl[20] = mk(1'b1, LW5,  1'b1, 1'b0, 1'b1, 1'b1, ADDI,  3'd0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd1);
    tbl[21] = mk(1'b1, ADD6, 1'b1, 1'b0, 1'b1, 1'b1, LW5,   3'd0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd5);
    // flush while in HAZ with a fetch offered: offer refused, slot emptied
    tbl[22] = mk(1'b1, SW,   1'b1, 1'b1, 1'b0, 1'b0, ADD6,  3'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd6);
    tbl[23] = mk(1'b0, SW,   1'b1, 1'b0, 1'b1, 1'b0, ADD6,  3'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd6);
    tbl[24] = mk(1'b1, ADD6, 1'b1, 1'b0, 1'b1, 1'b0, ADD6,  3'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd6);
    tbl[25] = mk(1'b0, ADD6, 1'b1, 1'b0, 1'b1, 1'b1, ADD6,  3'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd6);
    tbl[26] = mk(1'b0, ADD6, 1'b0, 1'b0, 1'b1, 1'b0, ADD6,  3'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd6);

    // Reset held with a fetch offered.
    RESET    = 1'b0;
    IF_VALID = 1'b1;
    IF_INSTR = ADDI;
    EX_READY = 1'b1;
    FLUSH    = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("reset IF_READY", {31'd0, IF_READY}, 32'd0);
    check("reset ID_VALID", {31'd0, ID_VALID}, 32'd0);
    check_fields("reset", 32'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      IF_VALID = tbl[i].v;
      IF_INSTR = tbl[i].instr;
      EX_READY = tbl[i].er;
      FLUSH    = tbl[i].fl;
      #1;
      check($sformatf("row%0d IF_READY", i), {31'd0, IF_READY}, {31'd0, tbl[i].rdy});
      check($sformatf("row%0d ID_VALID", i), {31'd0, ID_VALID}, {31'd0, tbl[i].vld});
      check_fields($sformatf("row%0d", i), tbl[i].e_instr, tbl[i].e_sel, tbl[i].e_has,
                   tbl[i].e_ill, tbl[i].e_rs1, tbl[i].e_rs2, tbl[i].e_rd);
      @(negedge CLK);
    end

    // Mid-stream asynchronous reset with a valid instruction in the slot.
    IF_VALID = 1'b1;
    IF_INSTR = ADDI;
    EX_READY = 1'b0;
    FLUSH    = 1'b0;
    @(negedge CLK);
    IF_VALID = 1'b0;
    #1;
    check("pre-reset ID_VALID", {31'd0, ID_VALID}, 32'd1);
    check("pre-reset ID_INSTR", ID_INSTR, ADDI);
    RESET = 1'b0;
    #1;
    check("midreset ID_VALID", {31'd0, ID_VALID}, 32'd0);
    check("midreset IF_READY", {31'd0, IF_READY}, 32'd0);
    check_fields("midreset", 32'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Recovery after reset release.
    @(negedge CLK);
    RESET    = 1'b1;
    IF_VALID = 1'b1;
    IF_INSTR = SW;
    EX_READY = 1'b1;
    #1;
    check("post-reset IF_READY", {31'd0, IF_READY}, 32'd1);
    check("post-reset ID_VALID", {31'd0, ID_VALID}, 32'd0);
    @(negedge CLK);
    IF_VALID = 1'b0;
    #1;
    check("post-reset issue ID_VALID", {31'd0, ID_VALID}, 32'd1);
    check_fields("post-reset", SW, 3'd1, 1'b1, 1'b0, 5'd2, 5'd1, 5'd4);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
